// File: rtl/act_skew_feeder_if.sv
// Activation handshake from the upstream source plus the skewed left-edge bus into the MAC array.
interface act_skew_feeder_if #(
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [ROWS*DATA_WIDTH-1:0] in_data;
    logic                       in_last;
    logic [ROWS*DATA_WIDTH-1:0] act_out;
    logic [ROWS-1:0]            act_valid;
    logic                       busy;
    logic                       done;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, act_out, act_valid, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, act_out, act_valid, busy, done
    );
endinterface

// File: rtl/act_skew_feeder.sv
// Diagonal-skew feeder for the systolic array: lane r delays each accepted vector element by r+1 cycles,
// injects zero bubbles on idle cycles, and drains the skew after the last vector before pulsing done.
module act_skew_feeder #(
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    act_skew_feeder_if.slave bus
);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_done;
    logic          w_accept;

    assign bus.in_ready = ~rst & (r_state != DRAIN);
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, STREAM: begin
                if (w_accept) begin
                    if (bus.in_last) begin
                        w_state_nxt = DRAIN;
                        w_cnt_nxt   = CW'(ROWS - 1);
                    end else begin
                        w_state_nxt = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (r_cnt == '0) w_state_nxt = IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // done is raised on the cycle the drain counter sits at zero, which is exactly when the
    // last vector's element reaches the output of the deepest lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= (w_state_nxt == DRAIN) && (w_cnt_nxt == '0);
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [r:0][DATA_WIDTH-1:0] r_d;
        logic [r:0]                 r_v;

        // Free-running shift: the PEs cannot stall, so idle cycles become zero-valued bubbles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_d <= '0;
                r_v <= '0;
            end else begin
                r_d[0] <= w_accept ? bus.in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                r_v[0] <= w_accept;
                for (int s = 1; s <= r; s++) begin
                    r_d[s] <= r_d[s-1];
                    r_v[s] <= r_v[s-1];
                end
            end
        end

        assign bus.act_out[r*DATA_WIDTH +: DATA_WIDTH] = r_d[r];
        assign bus.act_valid[r]                        = r_v[r];
    end
endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder (ROWS=4, DATA_WIDTH=8) with a cycle-level reference model.
module tb_act_skew_feeder;
    localparam int ROWS = 4;
    localparam int DW   = 8;
    localparam int VW   = ROWS * DW;
    localparam int OW   = VW + ROWS + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   drain_left = 0;
    bit   streaming = 1'b0;
    logic [VW-1:0] hd [0:255];
    bit            hv [0:255];

    always #5 clk = ~clk;

    act_skew_feeder_if #(.ROWS(ROWS), .DATA_WIDTH(DW)) bus ();
    act_skew_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Expected {act_out, act_valid, done, busy, in_ready} for the cycle now being sampled.
    function automatic logic [OW-1:0] exp_obs();
        logic [VW-1:0]   a;
        logic [ROWS-1:0] v;
        int              idx;
        a = '0;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            idx = (cyc - 1 - r) & 255;
            if (hv[idx]) begin
                a[r*DW +: DW] = hd[idx][r*DW +: DW];
                v[r] = 1'b1;
            end
        end
        return {a, v, drain_left == 1, streaming || drain_left > 0, !rst && drain_left == 0};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {bus.act_out, bus.act_valid, bus.done, bus.busy, bus.in_ready};
    endfunction

    // Present inputs for the current cycle, clock once, update the model, sample 1 ns later.
    task automatic run_cycle(input bit v, input logic [VW-1:0] d, input bit last);
        int idx;
        idx = cyc & 255;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = last;
        @(posedge clk);
        hv[idx] = 1'b0;
        hd[idx] = '0;
        if (rst) begin
            drain_left = 0;
            streaming  = 1'b0;
        end else if (drain_left > 0) begin
            drain_left--;
        end else if (v) begin
            hv[idx]   = 1'b1;
            hd[idx]   = d;
            streaming = !last;
            if (last) drain_left = ROWS;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        run_cycle(1'b1, 32'h11223344, 1'b0);
        run_cycle(1'b1, 32'h55667788, 1'b0);
        checks++;
        if (obs() !== exp_obs()) begin
            errors++; $display("FAIL reset_prestream got %h exp %h", obs(), exp_obs());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++; $display("FAIL reset_async got %h exp 0", obs());
        end
        for (int i = 0; i < 256; i++) begin
            hv[i] = 1'b0;
            hd[i] = '0;
        end
        drain_left = 0;
        streaming  = 1'b0;
        run_cycle(1'b1, 32'hDEADBEEF, 1'b1);
        checks++;
        if (obs() !== exp_obs()) begin
            errors++; $display("FAIL reset_hold got %h exp %h", obs(), exp_obs());
        end
        rst = 1'b0;
        run_cycle(1'b0, '0, 1'b0);
        checks++;
        if ({bus.busy, bus.in_ready, bus.done, bus.act_valid} !== 7'b0100000) begin
            errors++; $display("FAIL reset_release got busy=%b rdy=%b done=%b av=%b exp 0 1 0 0000",
                               bus.busy, bus.in_ready, bus.done, bus.act_valid);
        end
    endtask

    task automatic test_skew();
        logic [VW+ROWS-1:0] tab [0:4];
        tab = '{{32'h00000001, 4'b0001}, {32'h00000200, 4'b0010}, {32'h00030000, 4'b0100},
                {32'h04000000, 4'b1000}, {32'h00000000, 4'b0000}};
        run_cycle(1'b1, 32'h04030201, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) run_cycle(1'b0, '0, 1'b0);
            checks++;
            if ({bus.act_out, bus.act_valid} !== tab[i]) begin
                errors++; $display("FAIL skew_lane cyc %0d got %h/%b exp %h", i + 1, bus.act_out, bus.act_valid, tab[i]);
            end
            checks++;
            if (obs() !== exp_obs()) begin
                errors++; $display("FAIL skew_obs cyc %0d got %h exp %h", i + 1, obs(), exp_obs());
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0, rel, ndone, dcyc;
        bit rdy_bad;
        c0 = cyc; ndone = 0; dcyc = -1; rdy_bad = 1'b0;
        for (int i = 0; i < 11; i++) begin
            run_cycle(i < 6, VW'(32'h03020100 + 32'h10101010 * i), i == 5);
            rel = cyc - c0;
            checks++;
            if (obs() !== exp_obs()) begin
                errors++; $display("FAIL b2b_obs cyc %0d got %h exp %h", rel, obs(), exp_obs());
            end
            if (bus.done === 1'b1) begin ndone++; dcyc = rel; end
            if (rel >= 6 && rel <= 9 && bus.in_ready !== 1'b0) rdy_bad = 1'b1;
            if (rel == 9) begin
                checks++;
                if (bus.act_out[31:24] !== 8'h53 || bus.act_valid[3] !== 1'b1) begin
                    errors++; $display("FAIL b2b_lane3_v5 got %h/%b exp 53/1", bus.act_out[31:24], bus.act_valid[3]);
                end
            end
            if (rel == 10) begin
                checks++;
                if ({bus.in_ready, bus.busy} !== 2'b10) begin
                    errors++; $display("FAIL b2b_idle got rdy=%b busy=%b exp 1 0", bus.in_ready, bus.busy);
                end
            end
        end
        checks++;
        if (ndone !== 1 || dcyc !== 9) begin
            errors++; $display("FAIL b2b_done got %0d pulses at %0d exp 1 at 9", ndone, dcyc);
        end
        checks++;
        if (rdy_bad) begin
            errors++; $display("FAIL b2b_ready_low got in_ready high in 6..9 exp low");
        end
    endtask

    task automatic test_gaps();
        int c0, rel, ndone, dcyc;
        logic [3:0] l0, l3;
        c0 = cyc; ndone = 0; dcyc = -1; l0 = '0; l3 = '0;
        for (int i = 0; i < 9; i++) begin
            run_cycle(i == 0 || i == 3, (i == 3) ? 32'hB1B2B3B4 : 32'hA1A2A3A4, i == 3);
            rel = cyc - c0;
            checks++;
            if (obs() !== exp_obs()) begin
                errors++; $display("FAIL gaps_obs cyc %0d got %h exp %h", rel, obs(), exp_obs());
            end
            if (rel >= 1 && rel <= 4) l0[rel-1] = bus.act_valid[0];
            if (rel >= 4 && rel <= 7) l3[rel-4] = bus.act_valid[3];
            if (bus.done === 1'b1) begin ndone++; dcyc = rel; end
            if (rel == 7) begin
                checks++;
                if (bus.act_out[31:24] !== 8'hB1) begin
                    errors++; $display("FAIL gaps_lane3_v1 got %h exp b1", bus.act_out[31:24]);
                end
            end
        end
        checks++;
        if (l0 !== 4'b1001 || l3 !== 4'b1001) begin
            errors++; $display("FAIL gaps_bubbles got l0=%b l3=%b exp 1001 1001", l0, l3);
        end
        checks++;
        if (ndone !== 1 || dcyc !== 7) begin
            errors++; $display("FAIL gaps_done got %0d pulses at %0d exp 1 at 7", ndone, dcyc);
        end
    endtask

    task automatic test_backpressure();
        int c0, rel, first;
        logic [15:0] dmask;
        c0 = cyc; first = -1; dmask = '0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(i <= 5, (i == 0) ? 32'hC0C1C2C3 : 32'hD0D1D2D3, i <= 5);
            rel = cyc - c0;
            checks++;
            if (obs() !== exp_obs()) begin
                errors++; $display("FAIL bp_obs cyc %0d got %h exp %h", rel, obs(), exp_obs());
            end
            if (bus.done === 1'b1) dmask[rel] = 1'b1;
            if (bus.act_valid[0] === 1'b1 && rel > 1 && first < 0) first = rel;
            if (rel == 6) begin
                checks++;
                if (bus.act_out[7:0] !== 8'hD3) begin
                    errors++; $display("FAIL bp_new_tile got %h exp d3", bus.act_out[7:0]);
                end
            end
        end
        checks++;
        if (first !== 6) begin
            errors++; $display("FAIL bp_accept_cycle got %0d exp 6", first);
        end
        checks++;
        if (dmask !== 16'h0210) begin
            errors++; $display("FAIL bp_done got %h exp 0210", dmask);
        end
    endtask

    task automatic test_signed();
        int c0, rel;
        logic [7:0] sb [0:3];
        sb = '{8'hFF, 8'h80, 8'hFF, 8'h80};
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            run_cycle(i == 0, 32'h80FF80FF, i == 0);
            rel = cyc - c0;
            checks++;
            if (obs() !== exp_obs()) begin
                errors++; $display("FAIL signed_obs cyc %0d got %h exp %h", rel, obs(), exp_obs());
            end
            if (rel >= 1 && rel <= 4) begin
                checks++;
                if (bus.act_out[(rel-1)*DW +: DW] !== sb[rel-1] || bus.act_valid[rel-1] !== 1'b1) begin
                    errors++; $display("FAIL signed_lane%0d got %h exp %h", rel - 1, bus.act_out[(rel-1)*DW +: DW], sb[rel-1]);
                end
            end
            checks++;
            if (bus.done !== (rel == 4)) begin
                errors++; $display("FAIL signed_done cyc %0d got %b exp %b", rel, bus.done, rel == 4);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (2) run_cycle(1'b0, '0, 1'b0);
        rst = 1'b0;
        test_reset();
        test_skew();
        test_back_to_back();
        test_gaps();
        test_backpressure();
        test_signed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
